// File: rtl/step_sequencer.sv
// step_sequencer: NUM_CHANNELS x NUM_STEPS drum step sequencer.
// It walks a pattern grid at a runtime tempo and hands per-step channel
// triggers to the sample fetcher, one at a time, lowest channel first.
// Optional feature: define SWING_EN to lengthen even steps and shorten
// odd steps by a quarter period.
module step_sequencer #(
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_STEPS    = 12,
  parameter int PERIOD_W     = 32,
  parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int STEP_W       = $clog2(NUM_STEPS)
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              run,
  input  logic                              restart,
  input  logic [PERIOD_W-1:0]               step_period,
  input  logic [NUM_CHANNELS*NUM_STEPS-1:0] pattern,
  input  logic [NUM_CHANNELS-1:0]           channel_mute,
  input  logic                              req_ready,
  output logic                              req_valid,
  output logic [CH_W-1:0]                   req_channel,
  output logic [STEP_W-1:0]                 step_idx,
  output logic                              step_strobe,
  output logic                              overrun,
  output logic                              playing
);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  localparam logic [PERIOD_W:0] ONE_P = (PERIOD_W + 1)'(1);

  state_t                  state_q, state_d;
  logic [PERIOD_W-1:0]     count_q, count_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic                    strobe_q, strobe_d;
  logic                    overrun_q, overrun_d;
  logic [NUM_CHANNELS-1:0] pending_q, pending_d;
  logic                    valid_q, valid_d;
  logic [CH_W-1:0]         chan_q, chan_d;

  logic [PERIOD_W:0]       base_period;
  logic [PERIOD_W:0]       eff_period;
  logic                    tick_done;

  logic                    load;
  logic                    hold;
  logic                    found;
  logic [STEP_W-1:0]       new_step;
  logic [NUM_CHANNELS-1:0] column;
  logic [NUM_CHANNELS-1:0] low_mask;
  logic [CH_W-1:0]         low_idx;

  // Length of the step currently being timed, and whether it has elapsed.
  always_comb begin
    base_period = (step_period == '0) ? ONE_P : {1'b0, step_period};
`ifdef SWING_EN
    if (step_q[0] == 1'b0) begin
      eff_period = base_period + (base_period >> 2);
    end else begin
      eff_period = base_period - (base_period >> 2);
    end
    if (eff_period == '0) begin
      eff_period = ONE_P;
    end
`else
    eff_period = base_period;
`endif
    tick_done = ({1'b0, count_q} >= (eff_period - ONE_P));
  end

  // Play/pause FSM, step timing, pending-trigger bookkeeping and arbiter.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    step_d    = step_q;
    strobe_d  = 1'b0;
    overrun_d = 1'b0;
    pending_d = pending_q;
    valid_d   = valid_q;
    chan_d    = chan_q;
    load      = 1'b0;
    new_step  = step_q;
    hold      = valid_q & ~req_ready;
    column    = '0;
    low_mask  = '0;
    low_idx   = '0;
    found     = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d  = PLAY;
          count_d  = '0;
          load     = 1'b1;
          new_step = '0;
        end
      end
      PLAY: begin
        if (!run) begin
          state_d = PAUSE;
        end else if (tick_done) begin
          count_d  = '0;
          load     = 1'b1;
          new_step = (step_q == STEP_W'(NUM_STEPS - 1)) ? '0 : step_q + STEP_W'(1);
        end else begin
          count_d = count_q + PERIOD_W'(1);
        end
      end
      PAUSE: begin
        if (run) begin
          state_d = PLAY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int s = 0; s < NUM_STEPS; s++) begin
        if (STEP_W'(s) == new_step) begin
          column[c] = pattern[c*NUM_STEPS + s];
        end
      end
    end

    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!found && pending_q[i]) begin
        found       = 1'b1;
        low_idx     = CH_W'(i);
        low_mask[i] = 1'b1;
      end
    end

    if (load) begin
      // Unserved triggers of the old step are dropped; an in-flight
      // request survives because the fetcher may already be looking at it.
      step_d    = new_step;
      strobe_d  = 1'b1;
      overrun_d = |pending_q;
      pending_d = column & ~channel_mute;
      if (!hold) begin
        valid_d = 1'b0;
      end
    end else if (!hold) begin
      if (found) begin
        valid_d   = 1'b1;
        chan_d    = low_idx;
        pending_d = pending_q & ~low_mask;
      end else begin
        valid_d = 1'b0;
      end
    end

    if (restart) begin
      state_d   = IDLE;
      count_d   = '0;
      step_d    = '0;
      strobe_d  = 1'b0;
      overrun_d = 1'b0;
      pending_d = '0;
      valid_d   = 1'b0;
      chan_d    = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      step_q    <= '0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      chan_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      step_q    <= step_d;
      strobe_q  <= strobe_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      chan_q    <= chan_d;
    end
  end

  assign req_valid   = valid_q;
  assign req_channel = chan_q;
  assign step_idx    = step_q;
  assign step_strobe = strobe_q;
  assign overrun     = overrun_q;
  assign playing     = (state_q == PLAY);

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Parametrised multi-channel step sequencer for the drum machine. It replaces the fixed 4x12 beat/cursor timing with a configurable NUM_CHANNELS x NUM_STEPS pattern grid, a runtime tempo, and pause/restart control. On each step it queues a trigger for every enabled, unmuted channel and issues the triggers one at a time to the SD-card sample fetcher over a valid/ready handshake. It sits between the keyboard-driven pattern registers and sdcard_init, in the 50 MHz domain.

Parameters:
NUM_CHANNELS, 4, number of sound channels (1..16)
NUM_STEPS, 12, steps per pattern loop (2..64)
PERIOD_W, 32, width of step_period
CH_W, $clog2(NUM_CHANNELS) (min 1), width of req_channel
STEP_W, $clog2(NUM_STEPS), width of step_idx

Ports:
Clk  in  1  50 MHz clock
Reset  in  1  asynchronous, active-high reset
run  in  1  1 = play, 0 = pause (level)
restart  in  1  single-cycle pulse: return to step 0, drop pending work
step_period  in  PERIOD_W  Clk cycles per step; 0 is treated as 1
pattern  in  NUM_CHANNELS*NUM_STEPS  bit [c*NUM_STEPS+s] = channel c fires on step s
channel_mute  in  NUM_CHANNELS  1 = suppress the channel's triggers
req_ready  in  1  fetcher accepts the request
req_valid  out  1  trigger request pending
req_channel  out  CH_W  channel being requested
step_idx  out  STEP_W  current step (drives the cursor graphic)
step_strobe  out  1  one-cycle pulse when step_idx takes a new or replayed value
overrun  out  1  one-cycle pulse: triggers dropped at a step boundary
playing  out  1  high in PLAY

Behaviour:
- Reset (async): state IDLE; tick counter=0; pending=0. All outputs 0: step_idx, step_strobe, req_valid, req_channel, overrun, playing.
- FSM states: IDLE, PLAY, PAUSE.
  - IDLE→PLAY when run=1. The entry edge fires step 0: step_strobe=1, step_idx=0, counter=0.
  - PLAY→PAUSE when run=0. The counter freezes. Pending requests continue to be served. No new steps.
  - PAUSE→PLAY when run=1. Counting resumes from the frozen value with no strobe; the remaining step time is preserved.
  - restart, in any state, has priority over everything. Next edge: step_idx=0, counter=0, pending=0, req_valid=0 (the only case where valid drops without acceptance), state=IDLE. PLAY is then re-entered per the IDLE rule, so step 0 fires one cycle later if run=1.
- Tick counting in PLAY: counter increments each cycle.
  - When counter >= eff_period-1: counter←0, step_idx←(step_idx==NUM_STEPS-1 ? 0 : step_idx+1), step_strobe=1 for one cycle.
  - Using >= means a mid-step reduction of step_period advances on the next cycle.
- Pending load: at every strobe edge, pending ← column(new step_idx) & ~channel_mute.
  - channel_mute is sampled at that edge only.
- Overrun at a step boundary:
  - If any pending bits other than an in-flight request remain unserved, overrun pulses together with step_strobe.
  - The unserved bits are discarded and replaced by the new column.
  - An in-flight request (req_valid=1, not yet accepted) is retained, holding req_channel stable until accepted.
  - If the new column also contains that channel, the bit stays pending and the channel is re-requested after acceptance.
- Arbiter: fixed priority, lowest channel index first. req_valid/req_channel are registered.
  - req_valid rises the cycle after the strobe if pending≠0.
  - On the valid&ready edge the bit is cleared and the next pending channel is presented on the same edge. Throughput is 1 request/cycle.
  - req_valid and req_channel are stable while req_ready=0.
- Accept coinciding with a step boundary: the accepted bit counts as served (no overrun for it). The new column then loads.

Optional Feature:
SWING_EN
- Defined: steps with even step_idx last step_period + (step_period>>2) cycles. Steps with odd step_idx last step_period - (step_period>>2) cycles (minimum 1). Pair length is unchanged. Applies to the step currently being timed.
- Undefined: every step lasts eff_period = max(step_period,1).

Test Plan:
1. Reset, run=1, step_period=4, ch0 on all steps, req_ready=1 -> step_strobe at cycle 1 then every 4 cycles; step_idx 0..11 then wraps to 0; req_valid/req_channel=0 one cycle after each strobe.
2. Step 0 column has ch0, ch2, ch3; req_ready=1 -> req_channel 0, 2, 3 on three consecutive cycles; req_valid then drops.
3. req_ready=0, ch1 and ch2 on step 0, step_period=4 -> req_channel=1 held stable. At step 1: overrun pulses once, ch2 discarded, ch1 still valid.
4. run dropped at counter=2 for 10 cycles, then raised -> no strobe during pause; next strobe 2 cycles after resume (period 4).
5. restart at step 7 with req_valid=1 -> next cycle req_valid=0, step_idx=0; step_strobe one cycle later (run=1).
6. channel_mute=4'b0100 with ch2 set on all steps -> no request ever for channel 2; other channels unaffected.
